// File: rtl/ber_phase_scan_ctrl_if.sv
// Checker-side bundle between the phase scan controller (master) and the PRBS BER checker / RX phase mux (slave).
interface ber_scan_if #(
  parameter int PHASE_W = 2
);
  logic               i_valid;
  logic               i_chk_sync;
  logic               i_chk_err;
  logic               o_chk_enable;
  logic               o_chk_clear;
  logic [PHASE_W-1:0] o_phase;

  modport master (
    input  i_valid, i_chk_sync, i_chk_err,
    output o_chk_enable, o_chk_clear, o_phase
  );

  modport slave (
    output i_valid, i_chk_sync, i_chk_err,
    input  o_chk_enable, o_chk_clear, o_phase
  );
endinterface

// File: rtl/ber_phase_scan_ctrl.sv
// Sweeps the RX sampling phase, counts PRBS errors per phase and publishes the lowest-error phase.
// Defining BER_SCAN_TRACK_EN adds a post-scan TRACK state that re-measures the chosen phase and relocks.
module ber_phase_scan_ctrl #(
  parameter int N_PHASES  = 4,
  parameter int PHASE_W   = 2,
  parameter int MEAS_LEN  = 1023,
  parameter int ERR_W     = 16,
  parameter int ALIGN_TMO = 65535
`ifdef BER_SCAN_TRACK_EN
  , parameter int TRACK_THR = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  ber_scan_if.master         chk,
  output logic               o_busy,
  output logic               o_done,
  output logic [PHASE_W-1:0] o_best_phase,
  output logic [ERR_W-1:0]   o_best_err,
  output logic               o_no_lock
`ifdef BER_SCAN_TRACK_EN
  , output logic             o_relock
`endif
);

  localparam int BIT_W = $clog2(MEAS_LEN + 1);
  localparam int TMO_W = $clog2(ALIGN_TMO + 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(MEAS_LEN - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(ALIGN_TMO - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(N_PHASES - 1);
  localparam logic [ERR_W-1:0]   ERR_MAX    = '1;
`ifdef BER_SCAN_TRACK_EN
  localparam logic [ERR_W-1:0]   TRACK_LIM  = ERR_W'(TRACK_THR);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ALIGN,
    S_MEASURE,
    S_EVAL,
    S_NEXT,
    S_DONE
`ifdef BER_SCAN_TRACK_EN
    , S_TRACK
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_idx_q, phase_idx_d;
  logic [PHASE_W-1:0] best_phase_q, best_phase_d;
  logic [ERR_W-1:0]   best_err_q, best_err_d;
  logic               any_lock_q, any_lock_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               chk_enable_q, chk_enable_d;
  logic               chk_clear_q, chk_clear_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PHASE_W-1:0] best_phase_out_q, best_phase_out_d;
  logic [ERR_W-1:0]   best_err_out_q, best_err_out_d;
  logic               no_lock_q, no_lock_d;
  logic               relock_q, relock_d;
  logic               start_scan;
  logic [ERR_W-1:0]   err_inc;

  always_comb begin
    state_d          = state_q;
    phase_idx_d      = phase_idx_q;
    best_phase_d     = best_phase_q;
    best_err_d       = best_err_q;
    any_lock_d       = any_lock_q;
    tmo_d            = tmo_q;
    bit_cnt_d        = bit_cnt_q;
    err_cnt_d        = err_cnt_q;
    best_phase_out_d = best_phase_out_q;
    best_err_out_d   = best_err_out_q;
    no_lock_d        = no_lock_q;
    relock_d         = 1'b0;
    start_scan       = 1'b0;
    err_inc          = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) start_scan = 1'b1;
      end
      S_CLEAR: begin
        state_d = S_ALIGN;
        tmo_d   = '0;
      end
      S_ALIGN: begin
        if (chk.i_chk_sync) begin
          state_d    = S_MEASURE;
          any_lock_d = 1'b1;
          bit_cnt_d  = '0;
          err_cnt_d  = '0;
        end else if (tmo_q == TMO_LAST) begin
          // a phase that never aligns scores worst-possible so it can only win by default
          state_d   = S_EVAL;
          err_cnt_d = ERR_MAX;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_MEASURE: begin
        if (chk.i_valid) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (chk.i_chk_err) err_cnt_d = err_inc;
          if (bit_cnt_q == BIT_LAST) state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (err_cnt_q < best_err_q) begin
          best_err_d   = err_cnt_q;
          best_phase_d = phase_idx_q;
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (phase_idx_q == PHASE_LAST) begin
          state_d          = S_DONE;
          best_phase_out_d = best_phase_q;
          best_err_out_d   = best_err_q;
          no_lock_d        = ~any_lock_q;
        end else begin
          phase_idx_d = phase_idx_q + 1'b1;
          state_d     = S_CLEAR;
        end
      end
      S_DONE: begin
        if (i_start) begin
          start_scan = 1'b1;
`ifdef BER_SCAN_TRACK_EN
        end else if (any_lock_q) begin
          state_d   = S_TRACK;
          bit_cnt_d = '0;
          err_cnt_d = '0;
`endif
        end
      end
`ifdef BER_SCAN_TRACK_EN
      S_TRACK: begin
        if (i_start) begin
          start_scan = 1'b1;
        end else if (chk.i_valid) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (chk.i_chk_err) err_cnt_d = err_inc;
          if (bit_cnt_q == BIT_LAST) begin
            if (err_cnt_d > TRACK_LIM) begin
              start_scan = 1'b1;
              relock_d   = 1'b1;
            end else begin
              bit_cnt_d = '0;
              err_cnt_d = '0;
            end
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (start_scan) begin
      state_d      = S_CLEAR;
      phase_idx_d  = '0;
      best_err_d   = ERR_MAX;
      best_phase_d = '0;
      any_lock_d   = 1'b0;
    end

    // outputs are decoded from the next state so they register in step with it
    chk_clear_d  = (state_d == S_CLEAR);
    chk_enable_d = (state_d != S_IDLE);
    busy_d       = (state_d == S_CLEAR) || (state_d == S_ALIGN) || (state_d == S_MEASURE) ||
                   (state_d == S_EVAL)  || (state_d == S_NEXT);
`ifdef BER_SCAN_TRACK_EN
    done_d       = (state_d == S_DONE) || (state_d == S_TRACK);
`else
    done_d       = (state_d == S_DONE);
`endif
    if (state_d == S_IDLE)  phase_d = '0;
    else if (done_d)        phase_d = best_phase_out_d;
    else                    phase_d = phase_idx_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      phase_idx_q      <= '0;
      best_phase_q     <= '0;
      best_err_q       <= ERR_MAX;
      any_lock_q       <= 1'b0;
      tmo_q            <= '0;
      bit_cnt_q        <= '0;
      err_cnt_q        <= '0;
      chk_enable_q     <= 1'b0;
      chk_clear_q      <= 1'b0;
      phase_q          <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      best_phase_out_q <= '0;
      best_err_out_q   <= '0;
      no_lock_q        <= 1'b0;
      relock_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      phase_idx_q      <= phase_idx_d;
      best_phase_q     <= best_phase_d;
      best_err_q       <= best_err_d;
      any_lock_q       <= any_lock_d;
      tmo_q            <= tmo_d;
      bit_cnt_q        <= bit_cnt_d;
      err_cnt_q        <= err_cnt_d;
      chk_enable_q     <= chk_enable_d;
      chk_clear_q      <= chk_clear_d;
      phase_q          <= phase_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      best_phase_out_q <= best_phase_out_d;
      best_err_out_q   <= best_err_out_d;
      no_lock_q        <= no_lock_d;
      relock_q         <= relock_d;
    end
  end

  assign chk.o_chk_enable = chk_enable_q;
  assign chk.o_chk_clear  = chk_clear_q;
  assign chk.o_phase      = phase_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_best_phase     = best_phase_out_q;
  assign o_best_err       = best_err_out_q;
  assign o_no_lock        = no_lock_q;
`ifdef BER_SCAN_TRACK_EN
  assign o_relock         = relock_q;
`else
  logic unused_relock;
  assign unused_relock = relock_q;
`endif

endmodule

// File: tb/tb_ber_phase_scan_ctrl.sv
// Bench for ber_phase_scan_ctrl: a 16-bit and a 4-bit error-counter instance share one stimulus
// stream; each scan's expected result comes from a phase-level reference model via a scoreboard.
`timescale 1ns/1ps
module tb_ber_phase_scan_ctrl;
  localparam int N    = 4;
  localparam int PW   = 2;
  localparam int ML   = 16;
  localparam int TMO  = 32;
  localparam int EW_A = 16;
  localparam int EW_B = 4;

  typedef struct { int bp; int be; bit nl; } exp_t;
  typedef int delays_t [N];
  typedef logic [ML-1:0] errs_t [N];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, valid = 1'b0, sync = 1'b0, err = 1'b0;
  logic busy_a, done_a, nl_a, busy_b, done_b, nl_b;
  logic [PW-1:0]   bp_a, bp_b;
  logic [EW_A-1:0] be_a;
  logic [EW_B-1:0] be_b;
`ifdef BER_SCAN_TRACK_EN
  logic relock_a, relock_b;
`endif
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t mon_e;
  int   prev_bp = 0, prev_be_a = 0;
  logic da_p = 1'b0, db_p = 1'b0;
  int   clr_a = 0, clr_b = 0;

  ber_scan_if #(.PHASE_W(PW)) bus_a ();
  ber_scan_if #(.PHASE_W(PW)) bus_b ();
  assign bus_a.i_valid = valid;  assign bus_a.i_chk_sync = sync;  assign bus_a.i_chk_err = err;
  assign bus_b.i_valid = valid;  assign bus_b.i_chk_sync = sync;  assign bus_b.i_chk_err = err;

  ber_phase_scan_ctrl #(.N_PHASES(N), .PHASE_W(PW), .MEAS_LEN(ML), .ERR_W(EW_A), .ALIGN_TMO(TMO)) dut_a (
    .clk(clk), .rst(rst), .i_start(start), .chk(bus_a), .o_busy(busy_a), .o_done(done_a),
    .o_best_phase(bp_a), .o_best_err(be_a), .o_no_lock(nl_a)
`ifdef BER_SCAN_TRACK_EN
    , .o_relock(relock_a)
`endif
  );

  ber_phase_scan_ctrl #(.N_PHASES(N), .PHASE_W(PW), .MEAS_LEN(ML), .ERR_W(EW_B), .ALIGN_TMO(TMO)) dut_b (
    .clk(clk), .rst(rst), .i_start(start), .chk(bus_b), .o_busy(busy_b), .o_done(done_b),
    .o_best_phase(bp_b), .o_best_err(be_b), .o_no_lock(nl_b)
`ifdef BER_SCAN_TRACK_EN
    , .o_relock(relock_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Reference: each phase scores its error count (saturated) or all-ones if it never aligned;
  // the strictly lowest score wins, earliest phase on ties.
  function automatic exp_t model(input delays_t d, input errs_t e, input int w);
    exp_t r;
    int   all1, v;
    all1 = (1 << w) - 1;
    r.bp = 0; r.be = all1; r.nl = 1'b1;
    for (int p = 0; p < N; p++) begin
      if (d[p] == 0) v = all1;
      else begin
        v = $countones(e[p]);
        if (v > all1) v = all1;
        r.nl = 1'b0;
      end
      if (v < r.be) begin r.be = v; r.bp = p; end
    end
    return r;
  endfunction

  function automatic logic [ML-1:0] pattern(input int n);
    logic [ML-1:0] v;
    v = '0;
    while ($countones(v) < n) v[$urandom_range(0, ML-1)] = 1'b1;
    return v;
  endfunction

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus_a.o_chk_clear && n < 200);
    if (!bus_a.o_chk_clear) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no clear pulse within 200 cycles", tag);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_a && n < 200) begin @(negedge clk); n++; end
    if (!done_a) begin
      n_tests++; n_fail++;
      $display("FAIL scan_done: o_done not seen within 200 cycles");
    end
  endtask

  // dly==0 means the checker never aligns; gap 0 none, 1 random, 2 every other cycle
  task automatic run_phase(input int p, input int dly, input logic [ML-1:0] e, input int gap, input int stop);
    check($sformatf("phase_out_p%0d", p), bus_a.o_phase, p);
    check("chk_enable_scan", bus_a.o_chk_enable, 1);
    sync = 1'b0;
    if (dly == 0) return;
    repeat (dly) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    for (int i = 0; i < ML; i++) begin
      if (i == stop) return;
      if (gap == 2 || (gap == 1 && $urandom_range(0, 2) == 0)) begin
        valid = 1'b0; err = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      valid = 1'b1; err = e[i];
      @(negedge clk);
    end
    valid = 1'b0; err = 1'b0;
  endtask

  task automatic run_scan(input delays_t d, input errs_t e, input int gap);
    exp_t ea, eb;
    ea = model(d, e, EW_A);
    eb = model(d, e, EW_B);
    exp_a.push_back(ea);
    exp_b.push_back(eb);
    start = 1'b1;
    for (int p = 0; p < N; p++) begin
      wait_clear("clear_wait");
      if (p == 0) begin
        start = 1'b0;
        check("rescan_done_drop", done_a, 0);
        check("rescan_busy", busy_a, 1);
        check("rescan_hold_phase", bp_a, prev_bp);
        check("rescan_hold_err", be_a, prev_be_a);
      end
      run_phase(p, d[p], e[p], gap, ML);
    end
    wait_done();
    prev_bp = ea.bp; prev_be_a = ea.be;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_en_a"}, bus_a.o_chk_enable, 0);
    check({tag, "_clr_a"}, bus_a.o_chk_clear, 0);
    check({tag, "_phase_a"}, bus_a.o_phase, 0);
    check({tag, "_busy_a"}, busy_a, 0);
    check({tag, "_done_a"}, done_a, 0);
    check({tag, "_bp_a"}, bp_a, 0);
    check({tag, "_be_a"}, be_a, 0);
    check({tag, "_nl_a"}, nl_a, 0);
    check({tag, "_busy_b"}, busy_b, 0);
    check({tag, "_be_b"}, be_b, 0);
  endtask

  // scoreboard monitor: each rising o_done pops one expected result per instance
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        clr_a = 0; clr_b = 0;
      end else begin
        if (bus_a.o_chk_clear) clr_a++;
        if (bus_b.o_chk_clear) clr_b++;
        if (done_a && !da_p) begin
          if (exp_a.size() == 0) begin
            n_fail++; $display("FAIL done_a: scan completed with nothing expected");
          end else begin
            mon_e = exp_a.pop_front();
            check("a_best_phase", bp_a, mon_e.bp);
            check("a_best_err", be_a, mon_e.be);
            check("a_no_lock", nl_a, mon_e.nl);
            check("a_phase_out", bus_a.o_phase, mon_e.bp);
            check("a_busy_done", busy_a, 0);
            check("a_enable_done", bus_a.o_chk_enable, 1);
            check("a_clear_pulses", clr_a, N);
          end
          clr_a = 0;
        end
        if (done_b && !db_p) begin
          if (exp_b.size() == 0) begin
            n_fail++; $display("FAIL done_b: scan completed with nothing expected");
          end else begin
            mon_e = exp_b.pop_front();
            check("b_best_phase", bp_b, mon_e.bp);
            check("b_best_err", be_b, mon_e.be);
            check("b_no_lock", nl_b, mon_e.nl);
            check("b_clear_pulses", clr_b, N);
          end
          clr_b = 0;
        end
      end
      da_p = done_a; db_p = done_b;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    delays_t d;
    errs_t   e;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_busy", busy_a, 0);
    check("idle_enable", bus_a.o_chk_enable, 0);

    d = '{5, 5, 5, 5};
    e[0] = pattern(7); e[1] = pattern(0); e[2] = pattern(3); e[3] = pattern(9);
    run_scan(d, e, 0);

    e[0] = pattern(2); e[1] = pattern(2); e[2] = pattern(5); e[3] = pattern(2);
    run_scan(d, e, 0);

    d = '{0, 0, 0, 0};
    run_scan(d, e, 0);

    d = '{5, 5, 5, 5};
    for (int p = 0; p < N; p++) e[p] = '1;
    run_scan(d, e, 2);

    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < N; p++) begin
        d[p] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 10));
        e[p] = pattern($urandom_range(0, ML));
      end
      run_scan(d, e, 1);
    end

    d = '{3, 4, 2, 5};
    start = 1'b1;
    for (int p = 0; p < 3; p++) begin
      wait_clear("abort_clear");
      start = 1'b0;
      run_phase(p, d[p], pattern(4), 1, (p == 2) ? 5 : ML);
    end
    rst = 1'b1; valid = 1'b0; err = 1'b0; sync = 1'b0;
    @(negedge clk);
    check_zero("midscan_rst");
    rst = 1'b0;
    prev_bp = 0; prev_be_a = 0;
    d = '{0, 6, 3, 2};
    e[0] = pattern(1); e[1] = pattern(6); e[2] = pattern(4); e[3] = pattern(12);
    run_scan(d, e, 1);

`ifdef BER_SCAN_TRACK_EN
    d = '{4, 4, 4, 4};
    for (int p = 0; p < N; p++) e[p] = pattern(2);
    run_scan(d, e, 0);
    @(negedge clk);
    e[0] = pattern(8);
    for (int i = 0; i < ML; i++) begin valid = 1'b1; err = e[0][i]; @(negedge clk); end
    valid = 1'b0; err = 1'b0;
    repeat (3) begin
      check("track_no_relock", relock_a, 0);
      check("track_done_high", done_a, 1);
      @(negedge clk);
    end
    e[0] = pattern(9);
    for (int i = 0; i < ML; i++) begin valid = 1'b1; err = e[0][i]; @(negedge clk); end
    valid = 1'b0; err = 1'b0;
    check("track_relock_a", relock_a, 1);
    check("track_relock_b", relock_b, 1);
    check("track_relock_busy", busy_a, 1);
    check("track_relock_phase", bus_a.o_phase, 0);
    @(negedge clk);
    check("track_relock_pulse", relock_a, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_a.size() + exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
